// File: rtl/vend_pkg.sv
// Shared types for the vending transaction controller.
// State encodings and the channel-index width helper.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vend_stock_bank.sv
// Per-channel stock counters with single-channel decrement and bulk reload.
// Counters saturate at zero so a channel can never wrap.
module vend_stock_bank
    import vend_pkg::*;
#(
    parameter int NUM_GOODS  = 4,
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 9,
    parameter int IDX_W      = idx_w(NUM_GOODS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         dec,
    input  logic [IDX_W-1:0]             dec_idx,
    input  logic                         reload,
    output logic [NUM_GOODS*STOCK_W-1:0] stock_cnt,
    output logic [NUM_GOODS-1:0]         sold_out
);

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_GOODS; i++) begin
            if (rst || reload) begin
                stock_cnt[i*STOCK_W +: STOCK_W] <= STOCK_W'(INIT_STOCK);
            end else if (dec && dec_idx == IDX_W'(i)
                         && stock_cnt[i*STOCK_W +: STOCK_W] != '0) begin
                stock_cnt[i*STOCK_W +: STOCK_W] <=
                    stock_cnt[i*STOCK_W +: STOCK_W] - 1'b1;
            end
        end
    end

    always_comb begin
        sold_out = '0;
        for (int i = 0; i < NUM_GOODS; i++) begin
            sold_out[i] = (stock_cnt[i*STOCK_W +: STOCK_W] == '0);
        end
    end

endmodule

// File: rtl/vend_ctrl.sv
// Vending transaction controller: credit accumulation, selection check,
// vend/change sequencing, cancel and inactivity refund.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int NUM_GOODS   = 4,
    parameter int PRICE_W     = 8,
    parameter int CREDIT_W    = 12,
    parameter int STOCK_W     = 4,
    parameter int INIT_STOCK  = 9,
    parameter int TIMEOUT_CYC = 5000,
    localparam int IDX_W      = idx_w(NUM_GOODS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         coin_valid,
    input  logic [CREDIT_W-1:0]          coin_value,
    input  logic [NUM_GOODS-1:0]         sel,
    input  logic                         buy,
    input  logic                         cancel,
    input  logic                         restock,
    input  logic [NUM_GOODS*PRICE_W-1:0] price_table,
    output logic [CREDIT_W-1:0]          credit,
    output logic [PRICE_W-1:0]           sel_price,
    output logic                         vend_valid,
    output logic [IDX_W-1:0]             vend_idx,
    output logic                         change_valid,
    output logic [CREDIT_W-1:0]          change_amt,
    output logic                         coin_reject,
    output logic                         no_funds,
    output logic [NUM_GOODS-1:0]         sold_out,
    output logic [NUM_GOODS*STOCK_W-1:0] stock_cnt,
    output logic [1:0]                   state
);

    localparam int TW = $clog2(TIMEOUT_CYC);

    state_t               st;
    logic [TW-1:0]        timer;
    logic [NUM_GOODS-1:0] sel_q;
    logic [PRICE_W-1:0]   lat_price;
    logic [IDX_W-1:0]     sel_idx;
    logic [PRICE_W-1:0]   price_mux;
    logic                 sel_ok;
    logic [CREDIT_W:0]    sum;
    logic [CREDIT_W-1:0]  cr_coin;
    logic                 coin_open;
    logic                 coin_ok;
    logic                 rej;
    logic                 can_buy;
    logic                 activity;

    always_comb begin
        sel_idx   = '0;
        price_mux = '0;
        for (int i = 0; i < NUM_GOODS; i++) begin
            if (sel[i]) begin
                sel_idx   = IDX_W'(i);
                price_mux = price_table[i*PRICE_W +: PRICE_W];
            end
        end
        sel_ok    = (sel != '0)
                    && ((sel & (sel - NUM_GOODS'(1))) == '0);
        sel_price = sel_ok ? price_mux : '0;
    end

    // Coin sum is one bit wider so overflow clamps to full scale.
    always_comb begin
        sum       = {1'b0, credit} + {1'b0, coin_value};
        coin_open = (st == ST_IDLE) || (st == ST_CREDIT);
        coin_ok   = coin_valid && coin_open && (coin_value != '0);
        rej       = coin_valid
                    && (!coin_open || coin_value == '0 || sum[CREDIT_W]);
        cr_coin   = credit;
        if (coin_ok) begin
            cr_coin = sum[CREDIT_W] ? '1 : sum[CREDIT_W-1:0];
        end
        can_buy   = (st == ST_CREDIT) && sel_ok && !sold_out[sel_idx]
                    && (credit >= CREDIT_W'(sel_price));
        activity  = coin_valid || buy || cancel || (sel != sel_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st           <= ST_IDLE;
            credit       <= '0;
            vend_valid   <= 1'b0;
            vend_idx     <= '0;
            change_valid <= 1'b0;
            change_amt   <= '0;
            coin_reject  <= 1'b0;
            no_funds     <= 1'b0;
            timer        <= '0;
            sel_q        <= '0;
            lat_price    <= '0;
        end else begin
            vend_valid   <= 1'b0;
            change_valid <= 1'b0;
            coin_reject  <= rej;
            no_funds     <= 1'b0;
            sel_q        <= sel;
            unique case (st)
                ST_IDLE: begin
                    timer    <= '0;
                    credit   <= cr_coin;
                    no_funds <= buy;
                    if (coin_ok) st <= ST_CREDIT;
                end
                ST_CREDIT: begin
                    credit <= cr_coin;
                    if (cancel) begin
                        st           <= ST_CHANGE;
                        change_amt   <= cr_coin;
                        change_valid <= 1'b1;
                        credit       <= '0;
                        timer        <= '0;
                    end else if (buy && can_buy) begin
                        st         <= ST_VEND;
                        vend_valid <= 1'b1;
                        vend_idx   <= sel_idx;
                        lat_price  <= sel_price;
                        timer      <= '0;
                    end else if (activity) begin
                        no_funds <= buy;
                        timer    <= '0;
                    end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
                        st           <= ST_CHANGE;
                        change_amt   <= credit;
                        change_valid <= 1'b1;
                        credit       <= '0;
                        timer        <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_VEND: begin
                    st           <= ST_CHANGE;
                    change_amt   <= credit - CREDIT_W'(lat_price);
                    change_valid <= (credit != CREDIT_W'(lat_price));
                    credit       <= '0;
                    no_funds     <= buy;
                end
                ST_CHANGE: begin
                    st       <= ST_IDLE;
                    no_funds <= buy;
                end
            endcase
        end
    end

    assign state = st;

    // Stock is debited while in VEND; a restock there would race it.
    vend_stock_bank #(
        .NUM_GOODS  (NUM_GOODS),
        .STOCK_W    (STOCK_W),
        .INIT_STOCK (INIT_STOCK),
        .IDX_W      (IDX_W)
    ) u_stock (
        .clk       (clk),
        .rst       (rst),
        .dec       (st == ST_VEND),
        .dec_idx   (vend_idx),
        .reload    (restock && (st != ST_VEND)),
        .stock_cnt (stock_cnt),
        .sold_out  (sold_out)
    );

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: vector table with scoreboard queue
// plus hand sequences for stock, timeout and reset corners.
module tb_vend_ctrl;

    localparam int TO = 5000;

    logic        clk = 1'b0;
    logic        rst;
    logic        coin_valid;
    logic [11:0] coin_value;
    logic [3:0]  sel;
    logic        buy;
    logic        cancel;
    logic        restock;
    logic [31:0] price_table;
    logic [11:0] credit;
    logic [7:0]  sel_price;
    logic        vend_valid;
    logic [1:0]  vend_idx;
    logic        change_valid;
    logic [11:0] change_amt;
    logic        coin_reject;
    logic        no_funds;
    logic [3:0]  sold_out;
    logic [15:0] stock_cnt;
    logic [1:0]  state;

    vend_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .coin_valid   (coin_valid),
        .coin_value   (coin_value),
        .sel          (sel),
        .buy          (buy),
        .cancel       (cancel),
        .restock      (restock),
        .price_table  (price_table),
        .credit       (credit),
        .sel_price    (sel_price),
        .vend_valid   (vend_valid),
        .vend_idx     (vend_idx),
        .change_valid (change_valid),
        .change_amt   (change_amt),
        .coin_reject  (coin_reject),
        .no_funds     (no_funds),
        .sold_out     (sold_out),
        .stock_cnt    (stock_cnt),
        .state        (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        cv;
        logic [11:0] cval;
        logic [3:0]  sel;
        logic        buy;
        logic        cancel;
        logic        restock;
        logic [1:0]  st;
        logic [11:0] cr;
        logic        vv;
        logic [1:0]  vidx;
        logic        cgv;
        logic [11:0] camt;
        logic        rej;
        logic        nf;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   stk[4];
    vec_t sb[$];
    vec_t tbl[$];

    function automatic vec_t mk(
        input logic cv, input int cval, input logic [3:0] s,
        input logic b, input logic c, input logic r,
        input logic [1:0] st, input int cr, input logic vv,
        input int vidx, input logic cgv, input int camt,
        input logic rej, input logic nf);
        vec_t v;
        v.cv = cv;   v.cval = 12'(cval); v.sel = s;
        v.buy = b;   v.cancel = c;       v.restock = r;
        v.st = st;   v.cr = 12'(cr);     v.vv = vv;
        v.vidx = 2'(vidx); v.cgv = cgv;  v.camt = 12'(camt);
        v.rej = rej; v.nf = nf;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        @(negedge clk);
        coin_valid = v.cv;
        coin_value = v.cval;
        sel        = v.sel;
        buy        = v.buy;
        cancel     = v.cancel;
        restock    = v.restock;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".state"}, state, e.st);
        chk({tag, ".credit"}, credit, e.cr);
        chk({tag, ".vend_valid"}, vend_valid, e.vv);
        chk({tag, ".change_valid"}, change_valid, e.cgv);
        chk({tag, ".coin_reject"}, coin_reject, e.rej);
        chk({tag, ".no_funds"}, no_funds, e.nf);
        if (e.vv) chk({tag, ".vend_idx"}, vend_idx, e.vidx);
        if (e.cgv) chk({tag, ".change_amt"}, change_amt, e.camt);
        coin_valid = 1'b0;
        buy        = 1'b0;
        cancel     = 1'b0;
        restock    = 1'b0;
    endtask

    task automatic chk_stock(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s.stock%0d", tag, i),
                stock_cnt[i*4 +: 4], stk[i]);
            chk($sformatf("%s.sold_out%0d", tag, i),
                sold_out[i], stk[i] == 0);
        end
    endtask

    initial begin
        int n;
        bit seen;
        logic [3:0] ps[5];
        int         pe[5];

        rst = 1'b1;
        coin_valid = 1'b0;
        coin_value = '0;
        sel = '0;
        buy = 1'b0;
        cancel = 1'b0;
        restock = 1'b0;
        price_table = {8'd30, 8'd20, 8'd15, 8'd10};
        for (int i = 0; i < 4; i++) stk[i] = 9;

        @(posedge clk);
        #1;
        chk("rst.state", state, 0);
        chk("rst.credit", credit, 0);
        chk("rst.vend_valid", vend_valid, 0);
        chk("rst.vend_idx", vend_idx, 0);
        chk("rst.change_valid", change_valid, 0);
        chk("rst.change_amt", change_amt, 0);
        chk("rst.coin_reject", coin_reject, 0);
        chk("rst.no_funds", no_funds, 0);
        chk_stock("rst");
        @(negedge clk);
        rst = 1'b0;

        ps = '{4'b0100, 4'b0011, 4'b1000, 4'b0001, 4'b0000};
        pe = '{20, 0, 30, 10, 0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sel = ps[i];
            #1;
            chk($sformatf("price%0d", i), sel_price, pe[i]);
        end

        // exact price, no change
        tbl.push_back(mk(1, 10, 1, 0, 0, 0, 1, 10, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 2, 10, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // coin 50 for ch2, coin during VEND rejected
        tbl.push_back(mk(1, 50, 4, 0, 0, 0, 1, 50, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 4, 1, 0, 0, 2, 50, 1, 2, 0, 0, 0, 0));
        tbl.push_back(mk(1, 10, 4, 0, 0, 0, 3, 0, 0, 0, 1, 30, 1, 0));
        tbl.push_back(mk(0, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // short credit, then cancel beats buy
        tbl.push_back(mk(1, 10, 8, 0, 0, 0, 1, 10, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8, 1, 0, 0, 1, 10, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 8, 1, 1, 0, 3, 0, 0, 0, 1, 10, 0, 0));
        tbl.push_back(mk(0, 0, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // buy in IDLE, zero coin
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        // coin with buy: judged on pre-coin credit
        tbl.push_back(mk(1, 20, 2, 0, 0, 0, 1, 20, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 10, 2, 1, 0, 0, 2, 30, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 2, 0, 0, 0, 3, 0, 0, 0, 1, 15, 0, 0));
        tbl.push_back(mk(0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // coin with cancel: refund includes coin
        tbl.push_back(mk(1, 5, 2, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 7, 2, 0, 1, 0, 3, 0, 0, 0, 1, 12, 0, 0));
        tbl.push_back(mk(0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // invalid selections
        tbl.push_back(mk(1, 40, 3, 0, 0, 0, 1, 40, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 3, 1, 0, 0, 1, 40, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 40, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 3, 0, 0, 0, 1, 40, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // saturation
        tbl.push_back(mk(1, 4090, 0, 0, 0, 0, 1, 4090, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 10, 0, 0, 0, 0, 1, 4095, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 3, 0, 0, 0, 1, 4095, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("t%0d", i));
        end
        stk[0] = 8; stk[1] = 8; stk[2] = 8; stk[3] = 9;
        chk_stock("tbl");

        // restock during VEND is ignored, in IDLE it reloads
        apply(mk(1, 10, 1, 0, 0, 0, 1, 10, 0, 0, 0, 0, 0, 0), "rv.coin");
        apply(mk(0, 0, 1, 1, 0, 0, 2, 10, 1, 0, 0, 0, 0, 0), "rv.buy");
        apply(mk(0, 0, 1, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0), "rv.rs");
        apply(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rv.idle");
        stk[0] = 7;
        chk_stock("rv");
        apply(mk(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "ri.rs");
        for (int i = 0; i < 4; i++) stk[i] = 9;
        chk_stock("ri");

        // drain channel 1
        for (int k = 0; k < 9; k++) begin
            string t;
            t = $sformatf("so%0d", k);
            apply(mk(1, 15, 2, 0, 0, 0, 1, 15, 0, 0, 0, 0, 0, 0), t);
            apply(mk(0, 0, 2, 1, 0, 0, 2, 15, 1, 1, 0, 0, 0, 0), t);
            apply(mk(0, 0, 2, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0), t);
            apply(mk(0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), t);
            stk[1]--;
        end
        chk_stock("so");
        apply(mk(1, 15, 2, 0, 0, 0, 1, 15, 0, 0, 0, 0, 0, 0), "so.c");
        apply(mk(0, 0, 2, 1, 0, 0, 1, 15, 0, 0, 0, 0, 0, 1), "so.b");
        apply(mk(0, 0, 2, 0, 1, 0, 3, 0, 0, 0, 1, 15, 0, 0), "so.x");
        apply(mk(0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "so.i");
        apply(mk(0, 0, 2, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "so.r");
        stk[1] = 9;
        chk_stock("rs");

        // inactivity refund
        apply(mk(1, 20, 4, 0, 0, 0, 1, 20, 0, 0, 0, 0, 0, 0), "to.c");
        n = 0;
        seen = 0;
        while (!seen && n < TO + 10) begin
            @(posedge clk);
            #1;
            n++;
            if (change_valid) seen = 1;
        end
        chk("to.fired", seen, 1);
        chk("to.window", (n >= TO - 1) && (n <= TO + 1), 1);
        chk("to.amt", change_amt, 20);
        chk("to.state", state, 3);
        chk("to.credit", credit, 0);
        apply(mk(0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "to.i");
        apply(mk(0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "to.b");

        // reset in VEND
        apply(mk(1, 10, 1, 0, 0, 0, 1, 10, 0, 0, 0, 0, 0, 0), "rr.c");
        apply(mk(0, 0, 1, 1, 0, 0, 2, 10, 1, 0, 0, 0, 0, 0), "rr.b");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rr.state", state, 0);
        chk("rr.credit", credit, 0);
        chk("rr.vend_valid", vend_valid, 0);
        chk("rr.vend_idx", vend_idx, 0);
        chk("rr.change_valid", change_valid, 0);
        chk("rr.change_amt", change_amt, 0);
        chk_stock("rr");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rr.after_cv", change_valid, 0);

        chk("sb.empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
